// File: rtl/cv32e40p_ft_err_manager.sv
// cv32e40p_ft_err_manager
// Purpose: watches the per-triplet error flags of the TMR majority voters and
// decides what the core should do about them. A lane that the voter corrects
// once is treated as a transient upset and triggers a replica resync over a
// req/ack handshake. A lane that errors PERM_THR valid cycles in a row is
// declared permanently broken. A lane that is detected but not corrected is
// uncorrectable. Both fault classes park the block in an absorbing FAULT state
// with sticky flags until clear_i or reset. Saturating counters keep
// statistics throughout.
//
// Ports:
//   clk              clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   valid_i          voter flags are meaningful this cycle
//   err_corrected_i  per-lane voter correction flag
//   err_detected_i   per-lane voter detection flag
//   clear_i          synchronous clear of counters, sticky flags and FSM
//   resync_ack_i     replica resync complete
//   resync_req_o     resync request, held high until acknowledged
//   perm_fault_o     sticky permanent-fault flag
//   uncorrectable_o  sticky uncorrectable-error flag
//   fault_lane_o     lanes that caused FAULT entry, frozen afterwards
//   corr_cnt_o       saturating count of cycles with >=1 corrected lane
//   uncorr_cnt_o     saturating count of cycles with >=1 uncorrectable lane
module cv32e40p_ft_err_manager #(
   parameter int N_IN     = 1,
   parameter int CNT_W    = 8,
   parameter int PERM_THR = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [N_IN-1:0]  err_corrected_i,
   input  logic [N_IN-1:0]  err_detected_i,
   input  logic             clear_i,
   input  logic             resync_ack_i,
   output logic             resync_req_o,
   output logic             perm_fault_o,
   output logic             uncorrectable_o,
   output logic [N_IN-1:0]  fault_lane_o,
   output logic [CNT_W-1:0] corr_cnt_o,
   output logic [CNT_W-1:0] uncorr_cnt_o
);

   // The streak counter must be able to hold PERM_THR itself so it can saturate there.
   localparam int CW = $clog2(PERM_THR + 1);
   localparam logic [CW-1:0]    STREAK_MAX  = CW'(PERM_THR);
   localparam logic [CW-1:0]    STREAK_LAST = CW'(PERM_THR - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      IDLE,
      RESYNC,
      FAULT
   } state_t;

   state_t        state;
   logic [CW-1:0] consec [N_IN];

   logic [N_IN-1:0] unc;
   logic [N_IN-1:0] ev;
   logic [N_IN-1:0] perm;
   logic [N_IN-1:0] corr;

   // Event classification. Everything is gated by valid_i, so a cycle without
   // valid flags can never start a handshake or declare a fault.
   always_comb begin
      unc  = '0;
      ev   = '0;
      perm = '0;
      corr = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (valid_i) begin
            corr[k] = err_corrected_i[k];
            unc[k]  = err_detected_i[k] & ~err_corrected_i[k];
            ev[k]   = err_detected_i[k] | err_corrected_i[k];
            perm[k] = ev[k] & (consec[k] == STREAK_LAST);
         end
      end
   end

   // Per-lane streak of consecutive valid erroring cycles. Invalid cycles hold
   // the streak so a bubble in the pipeline does not hide a stuck lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_IN; k++) consec[k] <= '0;
      end else if (clear_i) begin
         for (int k = 0; k < N_IN; k++) consec[k] <= '0;
      end else if (valid_i) begin
         for (int k = 0; k < N_IN; k++) begin
            if (!ev[k])                      consec[k] <= '0;
            else if (consec[k] != STREAK_MAX) consec[k] <= consec[k] + 1'b1;
         end
      end
   end

   // Statistics counters; they keep running in FAULT so software can still
   // see how noisy the voters are after the core has been stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt_o   <= '0;
         uncorr_cnt_o <= '0;
      end else if (clear_i) begin
         corr_cnt_o   <= '0;
         uncorr_cnt_o <= '0;
      end else begin
         if (|corr && corr_cnt_o != CNT_MAX)  corr_cnt_o   <= corr_cnt_o + 1'b1;
         if (|unc && uncorr_cnt_o != CNT_MAX) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
      end
   end

   // Control FSM with registered outputs. Uncorrectable beats permanent beats
   // corrected; only the winning class is recorded in fault_lane_o.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         resync_req_o    <= 1'b0;
         perm_fault_o    <= 1'b0;
         uncorrectable_o <= 1'b0;
         fault_lane_o    <= '0;
      end else if (clear_i) begin
         state           <= IDLE;
         resync_req_o    <= 1'b0;
         perm_fault_o    <= 1'b0;
         uncorrectable_o <= 1'b0;
         fault_lane_o    <= '0;
      end else begin
         case (state)
            IDLE, RESYNC: begin
               if (|unc) begin
                  state           <= FAULT;
                  resync_req_o    <= 1'b0;
                  uncorrectable_o <= 1'b1;
                  fault_lane_o    <= unc;
               end else if (|perm) begin
                  state        <= FAULT;
                  resync_req_o <= 1'b0;
                  perm_fault_o <= 1'b1;
                  fault_lane_o <= perm;
               end else if (state == IDLE) begin
                  if (|corr) begin
                     state        <= RESYNC;
                     resync_req_o <= 1'b1;
                  end
               end else if (resync_ack_i) begin
                  state        <= IDLE;
                  resync_req_o <= 1'b0;
               end
            end
            FAULT: begin
               resync_req_o <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               resync_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40p_ft_err_manager.sv
// Testbench for cv32e40p_ft_err_manager (N_IN=2, CNT_W=3, PERM_THR=4).
// Directed scenarios check hand-derived constants; a random phase compares the
// DUT against a behavioural model that follows the classification rules.
module tb_cv32e40p_ft_err_manager;

   localparam int N_IN     = 2;
   localparam int CNT_W    = 3;
   localparam int PERM_THR = 4;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid;
   logic [N_IN-1:0]  corr;
   logic [N_IN-1:0]  det;
   logic             clear;
   logic             ack;
   logic             resync_req;
   logic             perm_fault;
   logic             uncorrectable;
   logic [N_IN-1:0]  fault_lane;
   logic [CNT_W-1:0] corr_cnt;
   logic [CNT_W-1:0] uncorr_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: mode 0 = idle, 1 = waiting for ack, 2 = faulted.
   int         m_mode;
   int         m_streak [N_IN];
   int         m_corr_cnt;
   int         m_uncorr_cnt;
   logic       m_req;
   logic       m_perm;
   logic       m_unc;
   logic [1:0] m_lanes;

   cv32e40p_ft_err_manager #(
      .N_IN(N_IN), .CNT_W(CNT_W), .PERM_THR(PERM_THR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid),
      .err_corrected_i(corr), .err_detected_i(det),
      .clear_i(clear), .resync_ack_i(ack),
      .resync_req_o(resync_req), .perm_fault_o(perm_fault),
      .uncorrectable_o(uncorrectable), .fault_lane_o(fault_lane),
      .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0;
      for (int k = 0; k < N_IN; k++) m_streak[k] = 0;
      m_corr_cnt   = 0;
      m_uncorr_cnt = 0;
      m_req        = 1'b0;
      m_perm       = 1'b0;
      m_unc        = 1'b0;
      m_lanes      = '0;
   endtask

   // One rising edge worth of behaviour, computed from the current inputs.
   task automatic model_step();
      logic [1:0] u, p;
      u = '0;
      p = '0;
      if (clear) begin
         model_reset();
         return;
      end
      if (valid) begin
         for (int k = 0; k < N_IN; k++) begin
            if (det[k] && !corr[k]) u[k] = 1'b1;
            if ((det[k] || corr[k]) && m_streak[k] + 1 == PERM_THR) p[k] = 1'b1;
            if (det[k] || corr[k]) m_streak[k] = (m_streak[k] < PERM_THR) ? m_streak[k] + 1 : PERM_THR;
            else                   m_streak[k] = 0;
         end
         if (corr != 0 && m_corr_cnt < CMAX)  m_corr_cnt++;
         if (u != 0 && m_uncorr_cnt < CMAX)   m_uncorr_cnt++;
      end
      if (m_mode != 2) begin
         if (u != 0) begin
            m_mode = 2; m_req = 1'b0; m_unc = 1'b1; m_lanes = u;
         end else if (p != 0) begin
            m_mode = 2; m_req = 1'b0; m_perm = 1'b1; m_lanes = p;
         end else if (m_mode == 0 && valid && corr != 0) begin
            m_mode = 1; m_req = 1'b1;
         end else if (m_mode == 1 && ack) begin
            m_mode = 0; m_req = 1'b0;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return at the
   // following falling edge where outputs are sampled.
   task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [1:0] d,
                                input logic clr, input logic a);
      valid = v; corr = c; det = d; clear = clr; ack = a;
      @(posedge clk);
      model_step();
      @(negedge clk);
      valid = 1'b0; corr = '0; det = '0; clear = 1'b0; ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; corr = '0; det = '0; clear = 1'b0; ack = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if ({resync_req, perm_fault, uncorrectable, fault_lane, corr_cnt, uncorr_cnt} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_initial: got req=%b perm=%b unc=%b lane=%b cc=%0d uc=%0d, expected all 0",
                  resync_req, perm_fault, uncorrectable, fault_lane, corr_cnt, uncorr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
      n_cmp++;
      if (resync_req !== 1'b1 || corr_cnt !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL reset_pre_req: got req=%b cc=%0d, expected req=1 cc=1", resync_req, corr_cnt);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({resync_req, perm_fault, uncorrectable, fault_lane, corr_cnt, uncorr_cnt} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_async: got req=%b cc=%0d, expected all 0", resync_req, corr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_resync();
      applyStimulus(1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
      n_cmp++;
      if (resync_req !== 1'b1 || corr_cnt !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL resync_req: got req=%b cc=%0d, expected req=1 cc=1", resync_req, corr_cnt);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      n_cmp++;
      if (resync_req !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL resync_hold: got req=%b, expected 1", resync_req);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
      n_cmp++;
      if (resync_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL resync_ack: got req=%b, expected 0", resync_req);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
      n_cmp++;
      if (resync_req !== 1'b0 || perm_fault !== 1'b0 || uncorrectable !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL idle_ack: got req=%b perm=%b unc=%b, expected 0 0 0",
                  resync_req, perm_fault, uncorrectable);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      n_cmp++;
      if (corr_cnt !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL clear_cnt: got cc=%0d, expected 0", corr_cnt);
      end
   endtask

   task automatic test_perm();
      // Four consecutive erroring cycles on lane 1.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b0 || resync_req !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL perm_early: got perm=%b req=%b, expected perm=0 req=1", perm_fault, resync_req);
      end
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b1 || fault_lane !== 2'b10 || resync_req !== 1'b0 || corr_cnt !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL perm_fire: got perm=%b lane=%b req=%b cc=%0d, expected 1 10 0 4",
                  perm_fault, fault_lane, resync_req, corr_cnt);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      // An invalid bubble does not break the streak.
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL perm_gap_early: got perm=%b, expected 0", perm_fault);
      end
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b1 || fault_lane !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL perm_gap: got perm=%b lane=%b, expected 1 10", perm_fault, fault_lane);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      // A clean valid cycle restarts the streak.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL perm_clean_reset: got perm=%b, expected 0", perm_fault);
      end
      applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      n_cmp++;
      if (perm_fault !== 1'b1 || fault_lane !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL perm_after_clean: got perm=%b lane=%b, expected 1 10", perm_fault, fault_lane);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
   endtask

   task automatic test_unc_in_resync();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      // Lane 0 uncorrectable and lane 1 reaching its permanent threshold together.
      applyStimulus(1'b1, 2'b10, 2'b11, 1'b0, 1'b0);
      n_cmp++;
      if (uncorrectable !== 1'b1 || perm_fault !== 1'b0 || fault_lane !== 2'b01 ||
          resync_req !== 1'b0 || uncorr_cnt !== 3'd1 || corr_cnt !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL unc_resync: got unc=%b perm=%b lane=%b req=%b uc=%0d cc=%0d, expected 1 0 01 0 1 4",
                  uncorrectable, perm_fault, fault_lane, resync_req, uncorr_cnt, corr_cnt);
      end
      applyStimulus(1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
      n_cmp++;
      if (corr_cnt !== 3'd5 || fault_lane !== 2'b01 || resync_req !== 1'b0 || uncorrectable !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL fault_absorb: got cc=%0d lane=%b req=%b unc=%b, expected 5 01 0 1",
                  corr_cnt, fault_lane, resync_req, uncorrectable);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
      n_cmp++;
      if (corr_cnt !== 3'd7 || uncorr_cnt !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL corr_saturate: got cc=%0d uc=%0d, expected 7 0", corr_cnt, uncorr_cnt);
      end
      applyStimulus(1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
      n_cmp++;
      if ({resync_req, perm_fault, uncorrectable, fault_lane, corr_cnt, uncorr_cnt} !== '0) begin
         n_fail++;
         $display("[TB] FAIL clear_with_corr: got req=%b perm=%b cc=%0d, expected all 0",
                  resync_req, perm_fault, corr_cnt);
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      n_cmp++;
      if (resync_req !== 1'b0 || corr_cnt !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL clear_no_req: got req=%b cc=%0d, expected 0 0", resync_req, corr_cnt);
      end
   endtask

   task automatic test_random();
      logic       v, clr, a;
      logic [1:0] c, d;
      for (int i = 0; i < 600; i++) begin
         v   = ($urandom % 4) != 0;
         c   = (($urandom % 8) < 3) ? 2'($urandom) : 2'b00;
         d   = (($urandom % 8) < 3) ? 2'($urandom) : 2'b00;
         clr = ($urandom % 30) == 0;
         a   = ($urandom % 4) == 0;
         applyStimulus(v, c, d, clr, a);
         n_cmp++;
         if (resync_req !== m_req || perm_fault !== m_perm || uncorrectable !== m_unc ||
             fault_lane !== m_lanes || int'(corr_cnt) != m_corr_cnt || int'(uncorr_cnt) != m_uncorr_cnt) begin
            n_fail++;
            $display("[TB] FAIL random_%0d: got req=%b perm=%b unc=%b lane=%b cc=%0d uc=%0d, expected %b %b %b %b %0d %0d",
                     i, resync_req, perm_fault, uncorrectable, fault_lane, corr_cnt, uncorr_cnt,
                     m_req, m_perm, m_unc, m_lanes, m_corr_cnt, m_uncorr_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_resync();
      test_perm();
      test_unc_in_resync();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
